// File: rtl/theta_slice.sv
// theta_slice: slice-serial Keccak-f[1600] theta stage.
// Each round takes one seed slice (standing in for slice 63 of the previous
// round), then 64 slices z = 0..63. Every accepted slice gets theta applied
// and is registered one cycle later. The column parity of each *input*
// slice is kept so that slice z can use the parity of slice z-1.
// Bit index inside a slice is 5*y + x.

module theta_slice (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_load,
    input  logic [0:24] pre_theta,
    input  logic        slice_valid,
    input  logic [0:24] slice_in,
    output logic [0:24] slice_out,
    output logic        out_valid,
    output logic        out_last,
    output logic        busy,
    output logic        seq_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Column parity: P[x] = xor over the five rows y of s[5y+x].
    function automatic logic [0:4] col_parity(input logic [0:24] s);
        logic [0:4] p;
        p[0] = s[0] ^ s[5] ^ s[10] ^ s[15] ^ s[20];
        p[1] = s[1] ^ s[6] ^ s[11] ^ s[16] ^ s[21];
        p[2] = s[2] ^ s[7] ^ s[12] ^ s[17] ^ s[22];
        p[3] = s[3] ^ s[8] ^ s[13] ^ s[18] ^ s[23];
        p[4] = s[4] ^ s[9] ^ s[14] ^ s[19] ^ s[24];
        return p;
    endfunction

    // Theta on one slice: D[x] = P(cur)[x-1] ^ prev[x+1], applied to every row.
    function automatic logic [0:24] theta_apply(input logic [0:24] s,
                                                input logic [0:4]  pv);
        logic [0:4] c;
        logic [0:4] d;
        c    = col_parity(s);
        d[0] = c[4] ^ pv[1];
        d[1] = c[0] ^ pv[2];
        d[2] = c[1] ^ pv[3];
        d[3] = c[2] ^ pv[4];
        d[4] = c[3] ^ pv[0];
        return s ^ {d, d, d, d, d};
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic [0:4] prev_r;
    logic [5:0] zcnt_r;
    logic       accept_s;
    logic       load_s;
    logic       err_s;
    logic       last_s;

    // Sequencing decisions: what the current inputs mean in the current state.
    always_comb begin
        accept_s   = 1'b0;
        load_s     = 1'b0;
        err_s      = 1'b0;
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pre_load) begin
                    // pre_load wins; a coincident slice is dropped and flagged
                    load_s     = 1'b1;
                    err_s      = slice_valid;
                    state_nx_s = ST_ARMED;
                end else if (slice_valid) begin
                    err_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (slice_valid) begin
                    // slice z = 0 uses the already-loaded seed; pre_load ignored
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else if (pre_load) begin
                    load_s = 1'b1;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (slice_valid) begin
                    accept_s = 1'b1;
                    if (zcnt_r == 6'd63) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
                // a seed mid-round (including on the final slice) is an error
                if (pre_load) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        last_s = accept_s && (zcnt_r == 6'd63);
    end

    // State register and the busy flag derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy    <= (state_nx_s != ST_IDLE);
        end
    end

    // Previous-slice parity and slice counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 5'd0;
            zcnt_r <= 6'd0;
        end else if (load_s) begin
            prev_r <= col_parity(pre_theta);
            zcnt_r <= 6'd0;
        end else if (accept_s) begin
            prev_r <= col_parity(slice_in);
            zcnt_r <= zcnt_r + 6'd1;
        end
    end

    // Output register: theta result, valid pulse and last-slice marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_out <= 25'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= accept_s;
            out_last  <= last_s;
            if (accept_s) begin
                slice_out <= theta_apply(slice_in, prev_r);
            end
        end
    end

    // Sticky sequencing-error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err <= 1'b0;
        end else if (err_s) begin
            seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_theta_slice.sv
// Self-checking bench for theta_slice: directed cases with constant
// expectations plus random rounds checked against a Keccak theta model.

module tb_theta_slice;

    logic        clk;
    logic        rst;
    logic        pre_load;
    logic [0:24] pre_theta;
    logic        slice_valid;
    logic [0:24] slice_in;
    logic [0:24] slice_out;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    theta_slice dut (
        .clk(clk), .rst(rst), .pre_load(pre_load), .pre_theta(pre_theta),
        .slice_valid(slice_valid), .slice_in(slice_in), .slice_out(slice_out),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keccak theta for lane slice z: A'[x,y] = A[x,y] ^ C[x-1,z] ^ C[x+1,z-1]
    function automatic logic [0:24] ref_theta(input logic [0:24] cur, input logic [0:24] prv);
        logic [0:24] r;
        logic c [5];
        logic cp [5];
        for (int x = 0; x < 5; x++) begin
            c[x] = 1'b0; cp[x] = 1'b0;
            for (int y = 0; y < 5; y++) begin
                c[x]  = c[x]  ^ cur[5*y+x];
                cp[x] = cp[x] ^ prv[5*y+x];
            end
        end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5*y+x] = cur[5*y+x] ^ c[(x+4)%5] ^ cp[(x+1)%5];
        return r;
    endfunction

    function automatic logic [0:24] rnd25();
        logic [31:0] w;
        w = $urandom;
        return w[24:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pl, input logic [0:24] pt, input logic sv, input logic [0:24] si);
        pre_load = pl; pre_theta = pt; slice_valid = sv; slice_in = si;
        tick();
        pre_load = 1'b0; slice_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pre_load = 1'b0; slice_valid = 1'b0;
        pre_theta = 25'd0; slice_in = 25'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [0:24] seed;
        do_reset();
        total++; if (slice_out !== 25'd0) begin bad++; $display("FAIL rst_slice_out got=%h want=0", slice_out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL rst_seq_err got=%b want=0", seq_err); end
        seed = rnd25();
        drive(1'b1, seed, 1'b0, 25'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 25'd0, 1'b1, rnd25() | 25'h1);
        // mid-RUN with an output in flight; reset acts without a clock edge
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%b want=0", out_valid); end
        total++; if (slice_out !== 25'd0) begin bad++; $display("FAIL async_slice_out got=%h want=0", slice_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
        tick();
        rst = 1'b0;
        drive(1'b0, 25'd0, 1'b1, rnd25());
        total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL idle_slice_err got=%b want=1", seq_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_slice_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_slice_busy got=%b want=0", busy); end
    endtask

    task automatic test_single_bit();
        logic [0:24] s;
        logic [0:24] e;
        do_reset();
        s = 25'd0; s[0] = 1'b1;
        e = 25'd0; e[0] = 1'b1; e[1] = 1'b1; e[6] = 1'b1; e[11] = 1'b1; e[16] = 1'b1; e[21] = 1'b1;
        drive(1'b1, 25'd0, 1'b0, 25'd0);
        drive(1'b0, 25'd0, 1'b1, s);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (slice_out !== e) begin bad++; $display("FAIL single_out got=%h want=%h", slice_out, e); end
    endtask

    task automatic test_seed_only();
        logic [0:24] sd;
        logic [0:24] e;
        do_reset();
        sd = 25'd0; sd[1] = 1'b1;
        e = 25'd0; e[0] = 1'b1; e[5] = 1'b1; e[10] = 1'b1; e[15] = 1'b1; e[20] = 1'b1;
        drive(1'b1, sd, 1'b0, 25'd0);
        drive(1'b0, 25'd0, 1'b1, 25'd0);
        total++; if (slice_out !== e || out_valid !== 1'b1) begin bad++; $display("FAIL seed_only got=%h/%b want=%h/1", slice_out, out_valid, e); end
    endtask

    task automatic test_chained();
        logic [0:24] s0;
        logic [0:24] e;
        do_reset();
        s0 = 25'd0; s0[2] = 1'b1;
        e = 25'd0; e[1] = 1'b1; e[6] = 1'b1; e[11] = 1'b1; e[16] = 1'b1; e[21] = 1'b1;
        drive(1'b1, 25'd0, 1'b0, 25'd0);
        drive(1'b0, 25'd0, 1'b1, s0);
        drive(1'b0, 25'd0, 1'b1, 25'd0);
        total++; if (slice_out !== e || out_valid !== 1'b1) begin bad++; $display("FAIL chained got=%h/%b want=%h/1", slice_out, out_valid, e); end
    endtask

    task automatic test_full_round();
        logic [0:24] prv, s, e, held, seed2;
        int g1, g2, g3;
        do_reset();
        prv = rnd25();
        g1 = $urandom_range(1, 20); g2 = $urandom_range(21, 40); g3 = $urandom_range(41, 63);
        drive(1'b1, prv, 1'b0, 25'd0);
        held = 25'd0;
        for (int z = 0; z < 64; z++) begin
            if (z == g1 || z == g2 || z == g3) begin
                drive(1'b0, 25'd0, 1'b0, 25'd0);
                total++; if (out_valid !== 1'b0 || slice_out !== held) begin bad++; $display("FAIL gap z=%0d got=%h/%b want=%h/0", z, slice_out, out_valid, held); end
            end
            s = rnd25();
            e = ref_theta(s, prv);
            prv = s;
            drive(1'b0, 25'd0, 1'b1, s);
            held = e;
            total++; if (out_valid !== 1'b1 || slice_out !== e) begin bad++; $display("FAIL round z=%0d got=%h/%b want=%h/1", z, slice_out, out_valid, e); end
            total++; if (out_last !== (z == 63)) begin bad++; $display("FAIL round_last z=%0d got=%b want=%b", z, out_last, (z == 63)); end
            total++; if (busy !== (z != 63)) begin bad++; $display("FAIL round_busy z=%0d got=%b want=%b", z, busy, (z != 63)); end
        end
        // next round starts immediately
        seed2 = rnd25();
        drive(1'b1, seed2, 1'b0, 25'd0);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL b2b_arm got=%b/%b/%b want=1/0/0", busy, out_valid, out_last); end
        s = rnd25();
        drive(1'b0, 25'd0, 1'b1, s);
        e = ref_theta(s, seed2);
        total++; if (slice_out !== e || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_slice got=%h want=%h", slice_out, e); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", seq_err); end
    endtask

    task automatic test_seq_err();
        logic [0:24] prv, s, e;
        do_reset();
        prv = rnd25();
        drive(1'b1, prv, 1'b0, 25'd0);
        for (int z = 0; z < 64; z++) begin
            if (z == 10) begin
                drive(1'b1, rnd25(), 1'b0, 25'd0);
                total++; if (seq_err !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL run_preload err/valid got=%b/%b want=1/0", seq_err, out_valid); end
            end
            s = rnd25();
            e = ref_theta(s, prv);
            prv = s;
            // a seed also rides along with slice 10 and with the final slice
            drive((z == 10 || z == 63), rnd25(), 1'b1, s);
            total++; if (out_valid !== 1'b1 || slice_out !== e || out_last !== (z == 63)) begin bad++; $display("FAIL err_round z=%0d got=%h/%b want=%h/1", z, slice_out, out_valid, e); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL last_preload_busy got=%b want=0", busy); end
        // IDLE with pre_load and slice together: seed taken, slice dropped
        prv = rnd25();
        drive(1'b1, prv, 1'b1, rnd25());
        total++; if (out_valid !== 1'b0 || busy !== 1'b1 || seq_err !== 1'b1) begin bad++; $display("FAIL idle_both got=%b/%b/%b want=0/1/1", out_valid, busy, seq_err); end
        s = rnd25();
        drive(1'b0, 25'd0, 1'b1, s);
        e = ref_theta(s, prv);
        total++; if (slice_out !== e || out_valid !== 1'b1) begin bad++; $display("FAIL idle_both_slice got=%h want=%h", slice_out, e); end
    endtask

    task automatic test_simul_armed();
        logic [0:24] sa, sb, s0, s1, e;
        do_reset();
        sa = rnd25();
        sb = sa ^ 25'h0000021;
        s0 = rnd25();
        s1 = rnd25();
        drive(1'b1, sa, 1'b0, 25'd0);
        drive(1'b1, sb, 1'b1, s0);
        e = ref_theta(s0, sa);
        total++; if (slice_out !== e || out_valid !== 1'b1) begin bad++; $display("FAIL armed_both got=%h want=%h", slice_out, e); end
        total++; if (seq_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL armed_both_flags got=%b/%b want=0/1", seq_err, busy); end
        drive(1'b0, 25'd0, 1'b1, s1);
        e = ref_theta(s1, s0);
        total++; if (slice_out !== e) begin bad++; $display("FAIL armed_next got=%h want=%h", slice_out, e); end
    endtask

    initial begin
        rst = 1'b1; pre_load = 1'b0; slice_valid = 1'b0;
        pre_theta = 25'd0; slice_in = 25'd0;
        #3;
        test_reset();
        test_single_bit();
        test_seed_only();
        test_chained();
        test_full_round();
        test_seq_err();
        test_simul_armed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/theta_slice.md
# theta_slice

Slice-serial Keccak-f[1600] theta stage, directly downstream of the pre-theta stage. Each round it takes one "previous-slice" seed from pre-theta, then 64 consecutive 25-bit slices (z = 0..63). For each slice it applies theta and registers the result for the rho/pi/chi path. Column parity of each input slice is retained so that slice z can use the parity of slice z-1. For z = 0 the seed stands in for slice 63.

## Interface
- No parameters; slice width is fixed at 25 and slices per round are fixed at 64.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- pre_load, input, 1: capture `pre_theta` as the previous-slice seed for the next round.
- pre_theta, input, [0:24]: seed slice from pre-theta; bit index is 5*y + x.
- slice_valid, input, 1: `slice_in` carries a valid slice this cycle.
- slice_in, input, [0:24]: input slice, bit index 5*y + x.
- slice_out, output, [0:24]: theta-applied slice, registered.
- out_valid, output, 1: `slice_out` is valid.
- out_last, output, 1: `slice_out` is slice z = 63.
- busy, output, 1: high in ARMED and RUN.
- seq_err, output, 1: sticky sequencing-error flag.

## Operation
- Column parity of a slice s: P(s)[x] = s[x]^s[x+5]^s[x+10]^s[x+15]^s[x+20], for x = 0..4.
- Theta per slice:
  - D[x] = P(in)[(x+4)%5] ^ prev[(x+1)%5]
  - out[5y+x] = in[5y+x] ^ D[x]
- `prev` register (5 bits) holds the parity used as "slice z-1":
  - On an accepted `pre_load` it loads P(pre_theta).
  - On each accepted slice it loads P(slice_in). This is the parity of the input slice, not of the output slice.
- Slice counter `zcnt` is 6 bits. It is cleared on `pre_load` and increments per accepted slice.
- State machine: IDLE, ARMED, RUN.
  - IDLE --pre_load--> ARMED.
  - ARMED --pre_load--> ARMED: reload `prev`, no error.
  - ARMED --slice_valid--> RUN: slice accepted as z = 0.
  - RUN --slice_valid with zcnt==63--> IDLE: `out_last` asserts next cycle.
  - RUN with slice_valid low: hold, gaps allowed.
- Error cases (each sets `seq_err`; `seq_err` clears only on `rst`):
  - `slice_valid` in IDLE: slice dropped, no output.
  - `pre_load` in RUN: ignored; `prev` and `zcnt` unchanged.
- Simultaneous `pre_load` and `slice_valid`:
  - In ARMED: the slice is processed with the old `prev`; `pre_load` is ignored, `seq_err` is not set, and the state moves to RUN.
  - In IDLE: `pre_load` wins; the slice is dropped and `seq_err` is set.
- On the same edge as the last slice (zcnt==63), a `pre_load` is treated as a RUN-state error.

## Timing
- Latency is 1 cycle: a slice accepted at edge n appears on `slice_out` with `out_valid` after edge n.
- `out_valid` is a one-cycle pulse per accepted slice. `out_last` is coincident with `out_valid` for z = 63.
- `slice_out` holds its last value when `out_valid` is low.
- Reset values: `slice_out` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `seq_err` = 0, `prev` = 0, `zcnt` = 0, state = IDLE.
- Reset mid-round: all state is cleared immediately. An in-flight output is lost (`out_valid` goes low asynchronously) and the next round needs a new `pre_load`.
- Back-to-back rounds: `pre_load` is legal in the cycle after the z = 63 slice is accepted, so 65 cycles per round is the minimum.

## Test plan
- Reset check: assert `rst` mid-RUN.
  - Required response: all outputs go to 0 immediately, state returns to IDLE.
  - Then send `slice_valid` without `pre_load`: `seq_err` = 1 and no `out_valid`.
- Single-bit current slice: `pre_load` with `pre_theta` = 0, then `slice_in` with only bit 0 set.
  - Required response: `slice_out` has bits {0,1,6,11,16,21} set, `out_valid` = 1.
- Seed only: `pre_theta` with only bit 1 set, then `slice_in` = 0.
  - Required response: `slice_out` bits {0,5,10,15,20} set.
- Chained slices: seed 0, slice 0 = bit 2 only, slice 1 = 0.
  - Required response: slice 1 output has bits {1,6,11,16,21} set, because prev[2] gives D[1].
  - The response must use the input parity of slice 0, not its output parity.
- Full round against a software Keccak theta:
  - 64 random slices with 3 gaps, random seed.
  - All 64 outputs match the model; `out_last` only on the 64th; `busy` drops after it.
  - A second `pre_load` follows immediately.
- Sequencing errors:
  - `pre_load` at z = 10 of RUN: `seq_err` = 1 and remaining outputs are unaffected.
  - Simultaneous `pre_load` and `slice_valid` in ARMED: processed with the old seed and `seq_err` stays 0.
